// File: rtl/muldiv_pkg.sv
// Shared encodings and decode helpers for the iterative multiply/divide unit.
// Control and result-mux logic import these so funct3 decode lives in one place.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdop_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdstate_t;

  function automatic logic is_div(input mdop_t op);
    return op[2];
  endfunction

  function automatic logic is_rem(input mdop_t op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(input mdop_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input mdop_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_iter_flopenr.sv
// Resettable register with load enable; holds the unit's result between operations.
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV M-extension unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign correction in a final FIX cycle.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  mdstate_t          r_state, w_state_next;
  mdop_t             r_op, w_op_in;
  logic [CW-1:0]     r_cnt;
  logic              r_neg_res, r_neg_rem;
  logic [XLEN-1:0]   r_a_mag, r_b_mag, r_quo, r_rem;
  logic [2*XLEN-1:0] r_prod;

  logic              w_accept, w_a_neg, w_b_neg, w_div0, w_ovf, w_special, w_last;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_spec_res, w_fix_res, w_res_d;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix;
  logic [XLEN:0]     w_mul_sum, w_div_shift;
  logic              w_div_ge;
  logic [2*XLEN-1:0] w_prod_fix;
  logic              w_res_en;

  assign w_op_in  = mdop_t'(funct3);
  assign ready    = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign busy     = (r_state == ST_CALC) || (r_state == ST_FIX);
  assign done     = (r_state == ST_DONE);
  assign w_accept = start && ready;
  assign w_last   = (r_cnt == CW'(XLEN-1));

  assign w_a_neg = is_signed_a(w_op_in) && a[XLEN-1];
  assign w_b_neg = is_signed_b(w_op_in) && b[XLEN-1];
  assign w_a_mag = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag = w_b_neg ? (~b + 1'b1) : b;

  // Only DIV/REM are signed among the divides, so is_signed_b doubles as the overflow qualifier.
  assign w_div0     = is_div(w_op_in) && (b == '0);
  assign w_ovf      = is_div(w_op_in) && is_signed_b(w_op_in) && (a == MIN_VAL) && (b == '1);
  assign w_special  = w_div0 || w_ovf;
  assign w_spec_res = w_div0 ? (is_rem(w_op_in) ? a : '1)
                             : (is_rem(w_op_in) ? '0 : MIN_VAL);

  assign w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, (r_prod[0] ? r_a_mag : '0)};
  assign w_div_shift = {r_rem, r_quo[XLEN-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b_mag});

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: w_state_next = w_accept ? (w_special ? ST_DONE : ST_CALC) : ST_IDLE;
      ST_CALC:          if (flush) w_state_next = ST_IDLE;
                        else if (w_last) w_state_next = ST_FIX;
      ST_FIX:           w_state_next = flush ? ST_IDLE : ST_DONE;
      default:          w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= OP_MUL;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_a_mag   <= '0;
      r_b_mag   <= '0;
      r_prod    <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
    end else if (w_accept) begin
      r_op      <= w_op_in;
      r_cnt     <= '0;
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      r_a_mag   <= w_a_mag;
      r_b_mag   <= w_b_mag;
      r_prod    <= {{XLEN{1'b0}}, w_b_mag};
      r_quo     <= w_a_mag;
      r_rem     <= '0;
    end else if (r_state == ST_CALC && !flush) begin
      r_cnt  <= r_cnt + 1'b1;
      r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
      // The restored remainder is always below the divisor, so XLEN bits hold it.
      r_rem  <= w_div_ge ? (w_div_shift[XLEN-1:0] - r_b_mag) : w_div_shift[XLEN-1:0];
      r_quo  <= {r_quo[XLEN-2:0], w_div_ge};
    end else if (r_state == ST_CALC) begin
      r_cnt <= '0;
    end
  end

  assign w_prod_fix = r_neg_res ? (~r_prod + 1'b1) : r_prod;
  assign w_quo_fix  = r_neg_res ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_fix  = r_neg_rem ? (~r_rem + 1'b1) : r_rem;

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      OP_MUL:                       w_fix_res = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_fix_res = w_quo_fix;
      OP_REM, OP_REMU:              w_fix_res = w_rem_fix;
      default:                      w_fix_res = '0;
    endcase
  end

  assign w_res_en = ((r_state == ST_FIX) && !flush) || (w_accept && w_special);
  assign w_res_d  = (r_state == ST_FIX) ? w_fix_res : w_spec_res;

  flopenr #(.WIDTH(XLEN)) u_result (
    .clk   (clk),
    .reset (reset),
    .en    (w_res_en),
    .d     (w_res_d),
    .q     (result)
  );

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter at XLEN=32 and XLEN=64 against a wide-arithmetic reference model.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, flush32, ready32, busy32, done32;
  logic [2:0]  f32;
  logic [31:0] a32, b32, res32;
  logic        start64, flush64, ready64, busy64, done64;
  logic [2:0]  f64;
  logic [63:0] a64, b64, res64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .funct3(f32), .a(a32), .b(b32),
    .flush(flush32), .ready(ready32), .busy(busy32), .done(done32), .result(res32)
  );

  muldiv_iter #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .funct3(f64), .a(a64), .b(b64),
    .flush(flush64), .ready(ready64), .busy(busy64), .done(done64), .result(res64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [129:0] ext(input int w, input logic [63:0] v, input logic sgn);
    logic signed [129:0] x;
    logic signed [129:0] one;
    one = 130'sd1;
    x = '0;
    x[63:0] = v & wmask(w);
    if (sgn && v[w-1]) x = x - (one << w);
    return x;
  endfunction

  function automatic bit is_special(input int w, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m;
    logic [63:0] minv;
    m = wmask(w);
    minv = 64'd1 << (w - 1);
    if (op < 3'd4) return 1'b0;
    if ((b & m) == 0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && ((a & m) == minv) && ((b & m) == m);
  endfunction

  // Reference: exact signed/unsigned arithmetic on wide integers.
  function automatic logic [63:0] model(input int w, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] sa, sb, p, q, r;
    logic [63:0] m, res;
    bit sgn_a, sgn_b;
    m = wmask(w);
    sgn_a = (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6);
    sgn_b = (op == 3'd1 || op == 3'd4 || op == 3'd6);
    sa = ext(w, a, sgn_a);
    sb = ext(w, b, sgn_b);
    if (op < 3'd4) begin
      p = sa * sb;
      res = (op == 3'd0) ? p[63:0] : 64'(p >> w);
    end else if ((b & m) == 0) begin
      res = op[1] ? a : m;
    end else if (is_special(w, op, a, b)) begin
      res = op[1] ? 64'd0 : (64'd1 << (w - 1));
    end else begin
      q = sa / sb;
      r = sa % sb;
      res = op[1] ? r[63:0] : q[63:0];
    end
    return res & m;
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0:       v = 64'd0;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = 64'd1 << (w - 1);
      3:       v = 64'($urandom_range(0, 20));
      default: v = {$urandom, $urandom};
    endcase
    return v & wmask(w);
  endfunction

  // Must be entered at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input bit w64, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        output int lat, output logic [63:0] res);
    if (w64) begin
      start64 = 1'b1; f64 = op; a64 = a; b64 = b;
    end else begin
      start32 = 1'b1; f32 = op; a32 = a[31:0]; b32 = b[31:0];
    end
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start32 = 1'b0;
      start64 = 1'b0;
    end while (!(w64 ? done64 : done32) && lat < 200);
    res = w64 ? res64 : {32'h0, res32};
    $display("op xlen=%0d f=%0d a=0x%0h b=0x%0h -> 0x%0h after %0d cycles",
             w64 ? 64 : 32, op, a, b, res, lat);
  endtask

  task automatic check_op(input string tag, input bit w64, input logic [2:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat);
    int lat;
    logic [63:0] res;
    run_op(w64, op, a, b, lat, res);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check(tag, res, exp);
  endtask

  logic [2:0]  d_op  [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
  logic [31:0] d_a   [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
  logic [31:0] d_b   [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
  logic [31:0] d_exp [14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                              32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                              32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd5};
  int          d_lat [14] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1, 1, 1};

  initial begin
    int lat;
    int done_seen;
    logic [63:0] prior, ra, rb, res;
    logic [2:0] rop;

    reset = 1'b1;
    start32 = 1'b0; flush32 = 1'b0; f32 = '0; a32 = '0; b32 = '0;
    start64 = 1'b0; flush64 = 1'b0; f64 = '0; a64 = '0; b64 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(ready32), 64'd1);
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_done", 64'(done32), 64'd0);
    check("rst_result", 64'(res32), 64'd0);
    check("rst_ready64", 64'(ready64), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++)
      check_op($sformatf("dir%0d", i), 1'b0, d_op[i], 64'(d_a[i]), 64'(d_b[i]), 64'(d_exp[i]), d_lat[i]);

    // Back-to-back from the DONE cycle of the previous op.
    check_op("b2b_first", 1'b0, 3'd0, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 34);
    check_op("b2b_second", 1'b0, 3'd5, 64'd100, 64'd7, 64'd14, 34);

    // start during CALC must be ignored.
    start32 = 1'b1; f32 = 3'd5; a32 = 32'd1000; b32 = 32'd9; lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start32 = (lat == 5);
      if (lat == 5) begin f32 = 3'd0; a32 = 32'd3; b32 = 32'd3; end
    end while (!done32 && lat < 200);
    start32 = 1'b0;
    $display("op xlen=32 f=5 a=0x3e8 b=0x9 with mid-CALC start -> 0x%0h after %0d cycles", res32, lat);
    check("ign_start_lat", 64'(lat), 64'd34);
    check("ign_start_res", 64'(res32), 64'd111);

    // Flush at CALC cycle 10.
    @(negedge clk);
    prior = 64'(res32);
    start32 = 1'b1; f32 = 3'd0; a32 = 32'd12345; b32 = 32'd678;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_busy_before", 64'(busy32), 64'd1);
    flush32 = 1'b1;
    @(negedge clk);
    flush32 = 1'b0;
    $display("flush xlen=32 during CALC: ready=%0d busy=%0d done=%0d result=0x%0h", ready32, busy32, done32, res32);
    check("flush_ready", 64'(ready32), 64'd1);
    check("flush_busy", 64'(busy32), 64'd0);
    check("flush_done", 64'(done32), 64'd0);
    check("flush_result", 64'(res32), prior);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) done_seen++;
    end
    check("flush_no_done", 64'(done_seen), 64'd0);
    check("flush_result_held", 64'(res32), prior);

    // Reset mid-CALC.
    start32 = 1'b1; f32 = 3'd3; a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("reset xlen=32 during CALC: ready=%0d busy=%0d done=%0d result=0x%0h", ready32, busy32, done32, res32);
    check("midrst_ready", 64'(ready32), 64'd1);
    check("midrst_busy", 64'(busy32), 64'd0);
    check("midrst_done", 64'(done32), 64'd0);
    check("midrst_result", 64'(res32), 64'd0);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = pick(32);
      rb = pick(32);
      check_op($sformatf("rnd32_%0d", i), 1'b0, rop, ra, rb, model(32, rop, ra, rb),
               is_special(32, rop, ra, rb) ? 1 : 34);
    end

    check_op("mul64", 1'b1, 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66);
    check_op("mulhu64", 1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFE, 66);
    check_op("div64_ovf", 1'b1, 3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h8000_0000_0000_0000, 1);
    for (int i = 0; i < 20; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = pick(64);
      rb = pick(64);
      check_op($sformatf("rnd64_%0d", i), 1'b1, rop, ra, rb, model(64, rop, ra, rb),
               is_special(64, rop, ra, rb) ? 1 : 66);
    end

    run_op(1'b0, 3'd7, 64'd100, 64'd7, lat, res);
    check("final_remu", res, 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
